// File: rtl/dram_bist_pkg.sv
// Shared types for the dram_bist block: sequencer states, March element codes
// and the per-channel checkerboard pattern helper.
package dram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_R0W1,
    ST_R1W0,
    ST_R0,
    ST_DONE
  } state_t;

  localparam logic [1:0] ELEM_R0W1 = 2'd0;
  localparam logic [1:0] ELEM_R1W0 = 2'd1;
  localparam logic [1:0] ELEM_R0   = 2'd2;

  // Odd channels carry the inverted background so neighbours never match.
  function automatic logic chk_pattern(input logic bg, input int unsigned c);
    return bg ^ c[0];
  endfunction

endpackage

// File: rtl/dram_dp_array.sv
// CHANNELS independent DEPTH x 1 dual-port RAMs: one synchronous write port
// shared with the spo read, plus an independent asynchronous dpo read.
module dram_dp_array #(
  parameter int              DEPTH    = 32,
  parameter int              CHANNELS = 2,
  parameter logic [DEPTH-1:0] INIT    = '0,
  parameter int              ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   a_i,
  input  logic [ADDR_W-1:0]   dpra_i,
  input  logic [CHANNELS-1:0] d_i,
  output logic [CHANNELS-1:0] spo_o,
  output logic [CHANNELS-1:0] dpo_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // Power-up content comes from the bitstream; there is no reset path.
    logic [DEPTH-1:0] mem_q = INIT;

    always_ff @(posedge clk_i) begin
      if (we_i) mem_q[a_i] <= d_i[c];
    end

    assign spo_o[c] = mem_q[a_i];
    assign dpo_o[c] = mem_q[dpra_i];
  end

endmodule

// File: rtl/dram_bist.sv
// Multi-channel dual-port LUT-RAM with a manual access path and a
// built-in March (W0, R0W1, R1W0, R0) self-test sequencer.
module dram_bist
  import dram_bist_pkg::*;
#(
  parameter int               DEPTH    = 32,
  parameter int               CHANNELS = 2,
  parameter logic [DEPTH-1:0] INIT     = '0,
  localparam int              ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_i,
  input  logic                start_i,
  input  logic                man_we_i,
  input  logic [ADDR_W-1:0]   man_addr_i,
  input  logic [ADDR_W-1:0]   man_dpra_i,
  input  logic [CHANNELS-1:0] man_d_i,
  output logic [CHANNELS-1:0] spo_o,
  output logic [CHANNELS-1:0] dpo_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ADDR_W-1:0]   fail_addr_o,
  output logic [1:0]          fail_elem_o,
  output logic [2:0]          dbg_state_o
);

  // Request protocol: start_i is a one-cycle pulse accepted only when idle
  // (IDLE or DONE, busy_o=0) with mode_i=1; busy_o rises on the accepting
  // edge, and done_o/pass_o stay valid until the next accepted start or rst.

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                busy_q, done_q, pass_q, ok_q;
  logic [ADDR_W-1:0]   fail_addr_q;
  logic [1:0]          fail_elem_q;

  logic                bist_act, chk_en, mism, wr_bg, exp_bg;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_a, ram_dpra;
  logic [CHANNELS-1:0] ram_d, exp_vec, wr_vec;
  logic [1:0]          cur_elem;

  assign bist_act = (state_q == ST_W0) || (state_q == ST_R0W1) ||
                    (state_q == ST_R1W0) || (state_q == ST_R0);
  assign chk_en   = (state_q == ST_R0W1) || (state_q == ST_R1W0) || (state_q == ST_R0);
  assign wr_bg    = (state_q == ST_R0W1);
  assign exp_bg   = (state_q == ST_R1W0);

  always_comb begin
    exp_vec  = '0;
    wr_vec   = '0;
    cur_elem = ELEM_R0W1;
    for (int c = 0; c < CHANNELS; c++) begin
      exp_vec[c] = chk_pattern(exp_bg, c);
      wr_vec[c]  = chk_pattern(wr_bg, c);
    end
    if (state_q == ST_R1W0) cur_elem = ELEM_R1W0;
    else if (state_q == ST_R0) cur_elem = ELEM_R0;
  end

  assign ram_we   = bist_act ? (state_q != ST_R0) : man_we_i;
  assign ram_a    = bist_act ? addr_q : man_addr_i;
  assign ram_dpra = bist_act ? addr_q : man_dpra_i;
  assign ram_d    = bist_act ? wr_vec : man_d_i;

  // Compared against the async read before the edge that commits the write.
  assign mism = chk_en && ((spo_o != exp_vec) || (dpo_o != exp_vec));

  dram_dp_array #(
    .DEPTH   (DEPTH),
    .CHANNELS(CHANNELS),
    .INIT    (INIT),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk_i (clk),
    .we_i  (ram_we),
    .a_i   (ram_a),
    .dpra_i(ram_dpra),
    .d_i   (ram_d),
    .spo_o (spo_o),
    .dpo_o (dpo_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      ok_q        <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= ok_q;
          end else if (start_i && mode_i) begin
            state_q     <= ST_W0;
            addr_q      <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ok_q        <= 1'b1;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
          end
        end
        ST_W0: begin
          if (addr_q == LAST) begin
            state_q <= ST_R0W1;
            addr_q  <= '0;
          end else addr_q <= addr_q + 1'b1;
        end
        ST_R0W1: begin
          if (addr_q == LAST) state_q <= ST_R1W0;
          else addr_q <= addr_q + 1'b1;
        end
        ST_R1W0: begin
          if (addr_q == '0) state_q <= ST_R0;
          else addr_q <= addr_q - 1'b1;
        end
        ST_R0: begin
          if (addr_q == LAST) begin
            state_q <= ST_DONE;
            addr_q  <= '0;
          end else addr_q <= addr_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (mism && ok_q) begin
        ok_q        <= 1'b0;
        fail_addr_q <= addr_q;
        fail_elem_q <= cur_elem;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign dbg_state_o = state_q;

endmodule
